// File: rtl/bias_acc_pkg.sv
// Shared widths, FSM state encoding and saturation-bound helpers for the bias/accumulate stage.
package bias_acc_pkg;

  localparam int DATA_W_DEF = 18;
  localparam int ACC_W_DEF  = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Signed range bounds for a w-bit two's-complement value.
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/bias_acc_lane.sv
// One output-channel lane: saturating accumulate, bias add, saturate to DATA_W.
// Optional ReLU on the final result when BIAS_ACC_RELU_EN is defined.
module bias_acc_lane
  import bias_acc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     accept,
  input  logic                     first,
  input  logic                     last,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] bias,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     clip
);

  localparam logic signed [ACC_W:0] ACC_HI  = (ACC_W+1)'(sat_max(ACC_W));
  localparam logic signed [ACC_W:0] ACC_LO  = (ACC_W+1)'(sat_min(ACC_W));
  localparam logic signed [ACC_W:0] DATA_HI = (ACC_W+1)'(sat_max(DATA_W));
  localparam logic signed [ACC_W:0] DATA_LO = (ACC_W+1)'(sat_min(DATA_W));

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] v);
    if (v > ACC_HI)      return ACC_HI[ACC_W-1:0];
    else if (v < ACC_LO) return ACC_LO[ACC_W-1:0];
    else                 return v[ACC_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [ACC_W:0] v);
    if (v > DATA_HI)      return DATA_HI[DATA_W-1:0];
    else if (v < DATA_LO) return DATA_LO[DATA_W-1:0];
    else                  return v[DATA_W-1:0];
  endfunction

  logic signed [ACC_W-1:0]  acc_p0;
  logic signed [DATA_W-1:0] res_p1;
  logic signed [ACC_W:0]    acc_x, in_x, bias_x, sum, r;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [DATA_W-1:0] res;
  logic                     acc_clip, res_clip;

  always_comb begin
    acc_x    = first ? '0 : {acc_p0[ACC_W-1], acc_p0};
    in_x     = {{(ACC_W+1-DATA_W){in_data[DATA_W-1]}}, in_data};
    bias_x   = {{(ACC_W+1-DATA_W){bias[DATA_W-1]}}, bias};
    sum      = acc_x + in_x;
    acc_clip = (sum > ACC_HI) || (sum < ACC_LO);
    acc_next = sat_acc(sum);
    r        = {acc_next[ACC_W-1], acc_next} + bias_x;
    res_clip = (r > DATA_HI) || (r < DATA_LO);
    res      = sat_data(r);
`ifdef BIAS_ACC_RELU_EN
    if (res[DATA_W-1]) res = '0;
`endif
    clip     = acc_clip || (last && res_clip);
  end

  // p0: accumulator; p1: biased, saturated result held for the output
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p0 <= '0;
      res_p1 <= '0;
    end else if (accept) begin
      acc_p0 <= acc_next;
      if (last) res_p1 <= res;
    end
  end

  assign out_data = res_p1;

endmodule

// File: rtl/bias_acc_stage.sv
// Per-pixel partial-sum accumulator with bias add and saturation across N lanes.
// Define BIAS_ACC_RELU_EN to clamp negative results to zero.
module bias_acc_stage
  import bias_acc_pkg::*;
#(
  parameter int N_adder_tree = 16,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ACC_W        = ACC_W_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N_adder_tree*DATA_W-1:0]   in_data,
  input  logic                             in_last,
  input  logic [N_adder_tree*DATA_W-1:0]   bias,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [N_adder_tree*DATA_W-1:0]   out_data,
  output logic                             sat_flag
);

  state_t                  state, state_nxt;
  logic                    accept, first;
  logic [N_adder_tree-1:0] clip;
  logic                    sat_p1;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        if (in_valid) state_nxt = in_last ? HOLD : ACCUM;
      end
      HOLD: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign first  = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)                         sat_p1 <= 1'b0;
    else if (accept)                 sat_p1 <= (first ? 1'b0 : sat_p1) | (|clip);
    else if (out_valid && out_ready) sat_p1 <= 1'b0;
  end

  assign sat_flag = sat_p1;

  for (genvar k = 0; k < N_adder_tree; k++) begin : g_lane
    bias_acc_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .accept   (accept),
      .first    (first),
      .last     (in_last),
      .in_data  (in_data[DATA_W*k +: DATA_W]),
      .bias     (bias[DATA_W*k +: DATA_W]),
      .out_data (out_data[DATA_W*k +: DATA_W]),
      .clip     (clip[k])
    );
  end

endmodule

// File: tb/tb_bias_acc_stage.sv
// Bench for bias_acc_stage: directed vectors, per-cycle compare against a behavioural model.
module tb_bias_acc_stage;

  localparam int N  = 16;
  localparam int DW = 18;
  localparam int AW = 24;
  localparam int BW = N * DW;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_last, out_valid, out_ready, sat_flag;
  logic [BW-1:0] in_data, bias, out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bias_acc_stage #(.N_adder_tree(N), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_flag  (sat_flag)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkv(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] lane(input logic [BW-1:0] v, input int k);
    return v[k*DW +: DW];
  endfunction

  function automatic logic [BW-1:0] one(input int k, input logic [DW-1:0] v);
    logic [BW-1:0] t;
    t = '0;
    t[k*DW +: DW] = v;
    return t;
  endfunction

  function automatic longint sx(input logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  // Behavioural model: plain integer accumulators clamped to the signed ranges
  longint        macc [N];
  longint        s, r;
  longint        amax, amin, dmax, dmin;
  bit            m_first, m_hold, m_sat, any;
  logic [BW-1:0] m_out;

  initial begin
    amax = (longint'(1) <<< (AW - 1)) - 1;
    amin = -(longint'(1) <<< (AW - 1));
    dmax = (longint'(1) <<< (DW - 1)) - 1;
    dmin = -(longint'(1) <<< (DW - 1));
  end

  always @(posedge clk) begin
    if (rst) begin
      m_hold = 0; m_first = 1; m_sat = 0; m_out = '0;
      foreach (macc[k]) macc[k] = 0;
    end else if (m_hold) begin
      if (out_ready) begin m_hold = 0; m_first = 1; end
    end else if (in_valid) begin
      any = 0;
      for (int k = 0; k < N; k++) begin
        s = (m_first ? 0 : macc[k]) + sx(in_data[k*DW +: DW]);
        if (s > amax) begin s = amax; any = 1; end
        else if (s < amin) begin s = amin; any = 1; end
        macc[k] = s;
        if (in_last) begin
          r = macc[k] + sx(bias[k*DW +: DW]);
          if (r > dmax) begin r = dmax; any = 1; end
          else if (r < dmin) begin r = dmin; any = 1; end
`ifdef BIAS_ACC_RELU_EN
          if (r < 0) r = 0;
`endif
          m_out[k*DW +: DW] = r[DW-1:0];
        end
      end
      m_sat   = (m_first ? 1'b0 : m_sat) | any;
      m_first = 0;
      if (in_last) m_hold = 1;
    end
  end

  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check1("cyc_in_ready", in_ready, !m_hold);
      check1("cyc_out_valid", out_valid, m_hold);
      if (m_hold) begin
        checkv("cyc_out_data", out_data, m_out);
        check1("cyc_sat_flag", sat_flag, m_sat);
      end
    end
  end

  task automatic drive(input logic [BW-1:0] d, input logic [BW-1:0] b, input logic last);
    in_valid = 1'b1; in_data = d; bias = b; in_last = last;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic get_result(output logic [BW-1:0] d, output logic sf);
    int n;
    check1("result_latency", out_valid, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL result_timeout: got out_valid=0 expected 1 within 20 cycles");
    end
    d  = out_data;
    sf = sat_flag;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [BW-1:0] d, held, bv;
  logic          sf;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; bias = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_in_ready", in_ready, 1'b1);
    checkv("rst_out_data", out_data, '0);
    check1("rst_sat_flag", sat_flag, 1'b0);
    rst = 1'b0;
    cmp_en = 1;

    // single beat
    drive(one(0, 18'h00100), one(0, 18'h06860), 1'b1);
    get_result(d, sf);
    checkv("t1_lane0", BW'(lane(d, 0)), BW'(18'h06960));
    checkv("t1_model", BW'(lane(m_out, 0)), BW'(18'h06960));
    check1("t1_sat", sf, 1'b0);

    // three max beats plus max bias
    for (int i = 0; i < 3; i++) drive(one(0, 18'h1FFFF), one(0, 18'h1FFFF), (i == 2));
    get_result(d, sf);
    checkv("t2_lane0", BW'(lane(d, 0)), BW'(18'h1FFFF));
    check1("t2_sat", sf, 1'b1);
    check1("t2_model_sat", m_sat, 1'b1);

    // negative lane1; bias on the first beat must be ignored
    drive(one(1, 18'h3FFC4), one(1, 18'h1FFFF), 1'b0);
    drive(one(1, 18'h3FFC4), one(1, 18'h3FFC4), 1'b1);
    get_result(d, sf);
`ifdef BIAS_ACC_RELU_EN
    checkv("t3_lane1", BW'(lane(d, 1)), BW'(18'h00000));
`else
    checkv("t3_lane1", BW'(lane(d, 1)), BW'(18'h3FF4C));
`endif
    check1("t3_sat", sf, 1'b0);

    // back-pressure: result held, beats ignored
    for (int k = 0; k < N; k++) begin
      d[k*DW +: DW] = DW'(k * 1000 - 7000);
      bv[k*DW +: DW] = DW'(k * 50);
    end
    drive(d, bv, 1'b1);
    check1("t4_valid", out_valid, 1'b1);
    held = out_data;
    checkv("t4_lane15", BW'(lane(held, 15)), BW'(18'h0222E));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_last = 1'b1; in_data = {N{18'h0AAAA}};
      @(negedge clk);
      checkv("t4_hold_data", out_data, held);
      check1("t4_hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    check1("t4_idle_ready", in_ready, 1'b1);
    check1("t4_idle_valid", out_valid, 1'b0);

    // accumulator saturation must clip, not wrap
    for (int i = 0; i < 70; i++) drive(one(2, 18'h1FFFF) | one(3, 18'h20000), '0, (i == 69));
    get_result(d, sf);
    checkv("t5_lane2", BW'(lane(d, 2)), BW'(18'h1FFFF));
`ifdef BIAS_ACC_RELU_EN
    checkv("t5_lane3", BW'(lane(d, 3)), BW'(18'h00000));
`else
    checkv("t5_lane3", BW'(lane(d, 3)), BW'(18'h20000));
`endif
    check1("t5_sat", sf, 1'b1);

    // reset mid-accumulation discards partial sums
    drive(one(0, 18'h00500), '0, 1'b0);
    drive(one(0, 18'h00500), '0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check1("t6_rst_valid", out_valid, 1'b0);
    check1("t6_rst_ready", in_ready, 1'b1);
    drive(one(0, 18'h00010), '0, 1'b1);
    get_result(d, sf);
    checkv("t6_lane0", BW'(lane(d, 0)), BW'(18'h00010));
    check1("t6_sat", sf, 1'b0);

    // reset while holding a result
    drive(one(4, 18'h00123), '0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check1("t7_rst_valid", out_valid, 1'b0);
    checkv("t7_rst_data", out_data, '0);

    // out_ready already high: result consumed in its first cycle
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      d[k*DW +: DW] = DW'(k * 37 - 300);
      bv[k*DW +: DW] = DW'(200 - k * 11);
    end
    drive(d, '0, 1'b0);
    drive(d, bv, 1'b1);
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    check1("t8_ready", in_ready, 1'b1);

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/bias_acc_stage.md
BIAS_ACC_STAGE -- requirements
Module: bias_acc_stage

Interface
REQ-001 SHALL have parameter N_adder_tree, default 16, number of parallel output-channel lanes.
REQ-002 SHALL have parameter DATA_W, default 18, lane width, two's-complement fixed point.
REQ-003 SHALL have parameter ACC_W, default 24, per-lane accumulator width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  partial-sum beat present.
REQ-007 SHALL have port in_ready  output  1  stage accepts a beat.
REQ-008 SHALL have port in_data  input  N_adder_tree*DATA_W  lane k at bits [DATA_W*(k+1)-1 : DATA_W*k].
REQ-009 SHALL have port in_last  input  1  final input-channel group of the current pixel.
REQ-010 SHALL have port bias  input  N_adder_tree*DATA_W  constant per-lane bias bus, same lane packing.
REQ-011 SHALL have port out_valid  output  1  biased result present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port out_data  output  N_adder_tree*DATA_W  biased, saturated result, same lane packing.
REQ-014 SHALL have port sat_flag  output  1  at least one lane saturated in the current result.

Function
REQ-015 SHALL run FSM states IDLE, ACCUM, HOLD; in_ready=1 in IDLE/ACCUM, 0 in HOLD.
REQ-016 SHALL define acceptance as in_valid&in_ready at a rising edge.
REQ-017 SHALL, on acceptance in IDLE, load acc[k]=sext(in_data[k]); in ACCUM, acc[k]+=sext(in_data[k]).
REQ-018 SHALL saturate every accumulator update to the signed ACC_W range; no wrap-around.
REQ-019 SHALL go IDLE->ACCUM on acceptance with in_last=0; stay in ACCUM on further in_last=0 beats.
REQ-020 SHALL, on acceptance with in_last=1 (from IDLE or ACCUM), compute per lane r=sext(acc_next)+sext(bias[k]) at ACC_W+1 bits, saturate to DATA_W, register it into out_data, and enter HOLD.
REQ-021 SHALL assert out_valid exactly in HOLD; latency from last-beat acceptance to out_valid is 1 cycle.
REQ-022 SHALL hold out_data and sat_flag stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, on out_valid&out_ready, return to IDLE next cycle; no new beat is accepted in that same cycle.
REQ-024 SHALL treat a single beat with in_last=1 in IDLE as a complete pixel (acc=in_data).
REQ-025 SHALL set sat_flag=1 if any lane clipped in REQ-018 or REQ-020 for the pixel; cleared on entering IDLE.
REQ-026 SHALL sample bias only in the last-beat cycle.

Reset
REQ-027 SHALL, with rst=1 at a clock edge, force IDLE, acc=0, out_valid=0, out_data=0, sat_flag=0; in_ready=1 after reset.
REQ-028 SHALL discard any partial accumulation or held result on reset mid-operation.

Configuration
REQ-029 SHALL support macro BIAS_ACC_RELU_EN: defined -> negative saturated lanes output 0 (ReLU applied after bias and saturation; sat_flag unaffected by ReLU); undefined -> signed result passed unchanged.

Structure
REQ-030 SHALL take DATA_W/ACC_W defaults, FSM state enum and sat helper constants (max/min for DATA_W, ACC_W) from a shared package bias_acc_pkg.
REQ-031 SHALL instantiate one sub-module per lane, bias_acc_lane (accumulate, bias add, saturate, optional ReLU); FSM and handshake stay in the top.

Verification
REQ-032 SHALL test one beat, lane0 in_data=0x00100, bias=0x06860, in_last=1 -> next cycle out_valid=1, lane0=0x06960, sat_flag=0.
REQ-033 SHALL test three beats of lane0 0x1FFFF (max +) and bias 0x1FFFF -> lane0=0x1FFFF, sat_flag=1.
REQ-034 SHALL test lane1 beats 0x3FFC4 then 0x3FFC4 (last), bias 0x3FFC4 -> without macro 0x3FF4C; with BIAS_ACC_RELU_EN 0x00000.
REQ-035 SHALL test out_ready=0 for 5 cycles after result -> out_data constant, in_ready=0, in_valid beats ignored; then out_ready=1 -> IDLE, in_ready=1.
REQ-036 SHALL test rst=1 asserted in ACCUM after 2 beats -> next cycle out_valid=0, in_ready=1; following single last beat 0x00010, bias 0 -> result 0x00010.
